// File: rtl/target_ctrl_pkg.sv
// Shared types and constants for the frog-target placement logic.
package target_ctrl_pkg;

  // Target address layout: {x[7:0], y[6:0]}
  localparam int ADDR_W = 15;
  localparam int X_MSB  = 14;
  localparam int X_LSB  = 7;
  localparam int Y_MSB  = 6;
  localparam int Y_LSB  = 0;
  localparam int X_W    = X_MSB - X_LSB + 1;
  localparam int Y_W    = Y_MSB - Y_LSB + 1;

  // Visible playfield and placement defaults
  localparam int unsigned        DEFAULT_MAX_X         = 160;
  localparam int unsigned        DEFAULT_MAX_Y         = 120;
  localparam int unsigned        DEFAULT_MAX_TRIES     = 16;
  localparam logic [ADDR_W-1:0]  DEFAULT_FALLBACK_ADDR = 15'h2814;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_SAMPLE,
    ST_CHECK,
    ST_QUERY,
    ST_ACTIVE
  } state_e;

endpackage

// File: rtl/target_bounds_check.sv
// Combinational on-screen test for a packed {x, y} cell address.
module target_bounds_check
  import target_ctrl_pkg::*;
#(
  parameter int unsigned MAX_X = DEFAULT_MAX_X,
  parameter int unsigned MAX_Y = DEFAULT_MAX_Y
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              in_range_o
);

  // One extra bit so a bound equal to 2**width still compares correctly
  localparam int XL_W = X_W + 1;
  localparam int YL_W = Y_W + 1;
  localparam logic [XL_W-1:0] MAX_X_L = XL_W'(MAX_X);
  localparam logic [YL_W-1:0] MAX_Y_L = YL_W'(MAX_Y);

  logic [X_W-1:0] x_field;
  logic [Y_W-1:0] y_field;

  assign x_field = addr_i[X_MSB:X_LSB];
  assign y_field = addr_i[Y_MSB:Y_LSB];

  // Unsigned compare of both fields against their exclusive upper bounds
  always_comb begin
    in_range_o = ({1'b0, x_field} < MAX_X_L) && ({1'b0, y_field} < MAX_Y_L);
  end

endmodule

// File: rtl/target_place_ctrl.sv
// Target placement sequencer: draws random candidates, discards off-screen
// or occupied cells, and falls back to a fixed cell after too many misses.
module target_place_ctrl
  import target_ctrl_pkg::*;
#(
  parameter int unsigned       MAX_X         = DEFAULT_MAX_X,
  parameter int unsigned       MAX_Y         = DEFAULT_MAX_Y,
  parameter int unsigned       MAX_TRIES     = DEFAULT_MAX_TRIES,
  parameter logic [ADDR_W-1:0] FALLBACK_ADDR = DEFAULT_FALLBACK_ADDR
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              TARGET_ATE,
  output logic              GEN_REQ,
  input  logic [ADDR_W-1:0] RND_ADDR,
  output logic              OCC_REQ,
  output logic [ADDR_W-1:0] OCC_ADDR,
  input  logic              OCC_ACK,
  input  logic              OCC_HIT,
  output logic [ADDR_W-1:0] TARGET_ADDR,
  output logic              TARGET_VALID,
  output logic              BUSY,
  output logic              FALLBACK_USED,
  output logic [7:0]        EATEN_CNT
);

  localparam logic [7:0] TRIES_LIMIT = 8'(MAX_TRIES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cand_q, cand_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [7:0]        tries_q, tries_d;
  logic [7:0]        eaten_q, eaten_d;
  logic              fb_q, fb_d;
  logic              cand_in_range;
  logic              reject;

  target_bounds_check #(
    .MAX_X (MAX_X),
    .MAX_Y (MAX_Y)
  ) u_bounds (
    .addr_i     (cand_q),
    .in_range_o (cand_in_range)
  );

  // Next-state and datapath updates for the placement sequence
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d  = state_q;
    cand_d   = cand_q;
    target_d = target_q;
    tries_d  = tries_q;
    eaten_d  = eaten_q;
    fb_d     = fb_q;
    reject   = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        tries_d = '0;
        state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        cand_d  = RND_ADDR;
        tries_d = tries_q + 8'd1;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (cand_in_range) state_d = ST_QUERY;
        else               reject  = 1'b1;
      end
      ST_QUERY: begin
        if (OCC_ACK) begin
          if (!OCC_HIT) begin
            target_d = cand_q;
            state_d  = ST_ACTIVE;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (TARGET_ATE) begin
          tries_d = '0;
          state_d = ST_SAMPLE;
          if (eaten_q != 8'hFF) eaten_d = eaten_q + 8'd1;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // A rejected candidate either retries or, once the budget is spent,
    // places the fixed cell without asking the occupancy map.
    if (reject) begin
      if (tries_q == TRIES_LIMIT) begin
        target_d = FALLBACK_ADDR;
        fb_d     = 1'b1;
        state_d  = ST_ACTIVE;
      end else begin
        state_d  = ST_SAMPLE;
      end
    end
  end

  // State and datapath registers; reset aborts any search immediately
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= ST_INIT;
      cand_q   <= '0;
      target_q <= '0;
      tries_q  <= '0;
      eaten_q  <= '0;
      fb_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together at the edge.
      state_q  <= state_d;
      cand_q   <= cand_d;
      target_q <= target_d;
      tries_q  <= tries_d;
      eaten_q  <= eaten_d;
      fb_q     <= fb_d;
    end
  end

  // Handshake strobes decode straight from state, so they are mutually exclusive
  assign GEN_REQ       = (state_q == ST_SAMPLE);
  assign OCC_REQ       = (state_q == ST_QUERY);
  assign OCC_ADDR      = cand_q;
  assign TARGET_ADDR   = target_q;
  assign TARGET_VALID  = (state_q == ST_ACTIVE);
  // Gated by reset so every output reads 0 while RESETN is held low
  assign BUSY          = RESETN && (state_q != ST_ACTIVE);
  assign FALLBACK_USED = fb_q;
  assign EATEN_CNT     = eaten_q;

endmodule

// File: doc/target_place_ctrl.md
Name: target_place_ctrl

Overview:
Sequencer that owns the random target generator and places each new frog target. On reset release and after every TARGET_ATE it requests one random address from the generator, rejects off-screen candidates, then queries the occupancy lookup (frog/obstacle map) so targets never spawn on an occupied cell. After MAX_TRIES rejections it falls back to a fixed address. Sits between game logic, the generator and the occupancy lookup; its TARGET_ADDR/TARGET_VALID drive the VGA draw and collision logic.

Parameters:
MAX_X, 160, exclusive upper bound on x field (RND_ADDR[14:7])
MAX_Y, 120, exclusive upper bound on y field (RND_ADDR[6:0])
MAX_TRIES, 16, candidate attempts before fallback (range 1..255)
FALLBACK_ADDR, 15'h2814, address used on exhaustion ({x=80, y=20})

Ports:
CLK  in  1  system clock
RESETN  in  1  reset, asynchronous, active-low
TARGET_ATE  in  1  one-cycle pulse from game logic: current target eaten
GEN_REQ  out  1  drives generator's TARGET_ATE; high only in SAMPLE
RND_ADDR  in  15  generator output {x[7:0], y[6:0]}, valid combinationally while GEN_REQ=1
OCC_REQ  out  1  occupancy query request, held until OCC_ACK
OCC_ADDR  out  15  candidate being queried; stable while OCC_REQ=1
OCC_ACK  in  1  query complete this cycle (may arrive in same cycle as OCC_REQ)
OCC_HIT  in  1  cell occupied; sampled only when OCC_ACK=1
TARGET_ADDR  out  15  placed target address
TARGET_VALID  out  1  TARGET_ADDR holds a live target
BUSY  out  1  high in every state except ACTIVE
FALLBACK_USED  out  1  sticky: at least one placement used FALLBACK_ADDR
EATEN_CNT  out  8  targets eaten, saturates at 255

Behaviour:
- Reset (RESETN=0, async): state INIT; all outputs 0; candidate reg 0; try counter 0. Mid-operation reset aborts any query immediately (OCC_REQ drops asynchronously).
- States: INIT, SAMPLE, CHECK, QUERY, ACTIVE.
- INIT -> SAMPLE unconditionally next cycle; try counter cleared.
- SAMPLE: GEN_REQ=1; cand <= RND_ADDR at clock edge; try counter +1; -> CHECK.
- CHECK: in-range iff cand[14:7] < MAX_X and cand[6:0] < MAX_Y (unsigned compares). In range -> QUERY; out of range -> SAMPLE, or PLACE-FALLBACK if try counter = MAX_TRIES.
- QUERY: OCC_REQ=1, OCC_ADDR=cand, held until OCC_ACK. On ACK with OCC_HIT=0 -> ACTIVE, TARGET_ADDR<=cand. On ACK with HIT=1 -> SAMPLE, or fallback if try counter = MAX_TRIES.
- Fallback: enter ACTIVE with TARGET_ADDR<=FALLBACK_ADDR, FALLBACK_USED<=1; no occupancy check.
- ACTIVE: TARGET_VALID=1, BUSY=0. TARGET_ATE=1 -> SAMPLE, TARGET_VALID=0 from next cycle, EATEN_CNT+1 (saturate), try counter cleared.
- TARGET_ATE outside ACTIVE: ignored, no count.
- Best-case latency: ATE at cycle n, SAMPLE n+1, CHECK n+2, QUERY n+3 with same-cycle ACK, TARGET_VALID=1 at n+4. Each OCC wait cycle adds 1; each rejection adds a full SAMPLE/CHECK(/QUERY) loop.
- TARGET_ADDR holds its value from placement until next placement; it is not cleared when TARGET_VALID drops.
- GEN_REQ and OCC_REQ never high together; OCC_REQ never high outside QUERY.

Decomposition:
- Package target_ctrl_pkg: state enum, address field slice constants (X_MSB=14, X_LSB=7, Y_MSB=6, Y_LSB=0), default MAX_X/MAX_Y.
- One sub-module: target_bounds_check (combinational in-range compare, parameterised by MAX_X/MAX_Y), reused by the draw logic.

Test Plan:
- Reset release, generator returns 15'h1405 ({x=40,y=5}), OCC_ACK same cycle HIT=0 -> TARGET_VALID=1 with TARGET_ADDR=15'h1405 four cycles after INIT exit; EATEN_CNT=0.
- In ACTIVE pulse TARGET_ATE; generator returns {x=200,y=5} then {x=10,y=10}; ACK=1 HIT=0 -> first candidate rejected with no OCC_REQ, TARGET_ADDR=15'h050A, EATEN_CNT=1.
- OCC_HIT=1 for first two queries, 0 on third; OCC_ACK delayed 3 cycles each -> OCC_ADDR stable during every wait, third candidate placed.
- Force every candidate out of range, MAX_TRIES=16 -> exactly 16 SAMPLE cycles, TARGET_ADDR=15'h2814, FALLBACK_USED=1.
- TARGET_ATE pulsed during QUERY and 300 times in ACTIVE -> mid-search pulse ignored; EATEN_CNT saturates at 255.
- Assert RESETN low while OCC_REQ=1 -> OCC_REQ, TARGET_VALID, EATEN_CNT, FALLBACK_USED all 0 without a clock edge; placement restarts from INIT.
